// File: rtl/flappy_game_state.sv
// flappy_game_state: frame-rate game engine for a one-pipe flappy-bird clone.
// Owns bird height/velocity, pipe column and gap row, score and game-over. Once per frame tick
// it advances physics (MOVE), tests for a collision (CHECK), then pulses draw_frame (EMIT) so
// the painter redraws from a state that stays stable until the next MOVE.
//
// Ports:
//   CLOCK_50    in   system clock
//   reset       in   synchronous, active-high reset
//   flap        in   synchronised level; a rising edge requests a flap
//   start       in   level; starts play from idle, restarts after game over
//   box_y       out  bird centre row
//   pipe_1_x    out  pipe column
//   pipe_1_y    out  top row of the pipe gap
//   draw_frame  out  one-cycle pulse, three cycles after each frame tick
//   game_over   out  high while the game is over
//   score       out  pipes passed, saturating at 255
module flappy_game_state #(
    parameter int unsigned FRAME_DIV    = 833333,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned FLAP_IMPULSE = 4,
    parameter int unsigned MAX_FALL     = 4,
    parameter int unsigned PIPE_SPEED   = 1,
    parameter int unsigned GAP_H        = 30,
    parameter int unsigned BOX_X        = 4,
    parameter int unsigned BOX_Y_INIT   = 60,
    parameter int unsigned PIPE_X_INIT  = 159,
    parameter int unsigned SCREEN_H     = 120,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       flap,
    input  logic       start,
    output logic [6:0] box_y,
    output logic [7:0] pipe_1_x,
    output logic [6:0] pipe_1_y,
    output logic       draw_frame,
    output logic       game_over,
    output logic [7:0] score
);

    localparam int unsigned     CntW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CntW-1:0] CntMax    = CntW'(FRAME_DIV - 1);
    localparam logic signed [6:0] GravS   = 7'(GRAVITY);
    localparam logic signed [6:0] MaxFall = 7'(MAX_FALL);
    localparam logic signed [5:0] FlapVel = 6'(0 - FLAP_IMPULSE);
    localparam logic signed [8:0] YMin    = 9'sd1;
    localparam logic signed [8:0] YMax    = 9'(SCREEN_H - 2);
    localparam logic [6:0]      BoxYInit  = 7'(BOX_Y_INIT);
    localparam logic [6:0]      BoxYMax   = 7'(SCREEN_H - 2);
    localparam logic [7:0]      PipeXInit = 8'(PIPE_X_INIT);
    localparam logic [7:0]      PipeStep  = 8'(PIPE_SPEED);
    localparam logic [6:0]      PipeYInit = 7'd40;
    localparam logic [8:0]      XLo       = 9'(BOX_X - 1);
    localparam logic [8:0]      XHi       = 9'(BOX_X + 1);
    localparam logic [8:0]      GapSpan   = 9'(GAP_H - 1);

    // Hold1/Hold2 pad the no-physics path so draw_frame keeps the same 3-cycle tick latency.
    typedef enum logic [2:0] {
        StIdle, StRun, StMove, StCheck, StEmit, StDead, StHold1, StHold2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              flap_prev_q;
    logic              flap_pend_q, flap_pend_d;
    logic signed [5:0] vel_q, vel_d;
    logic [6:0]        box_y_q, box_y_d;
    logic [7:0]        pipe_x_q, pipe_x_d;
    logic [6:0]        pipe_y_q, pipe_y_d;
    logic [7:0]        score_q, score_d;
    logic              over_q, over_d;
    logic              draw_q, draw_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic              hit_q, hit_d;
    logic              idle_path_q, idle_path_d;

    logic              tick;
    logic              flap_edge;
    logic signed [6:0] vel_sum;
    logic signed [5:0] vel_new;
    logic signed [8:0] y_sum;
    logic [6:0]        y_clamped;
    logic [8:0]        px9, by9, py9;
    logic              hit_now;

    // Frame divider and flap edge detect.
    always_comb begin
        tick      = (cnt_q == CntMax);
        cnt_d     = tick ? '0 : cnt_q + CntW'(1);
        flap_edge = flap & ~flap_prev_q;
    end

    // Physics for the MOVE step.
    always_comb begin
        vel_sum = $signed({vel_q[5], vel_q}) + GravS;
        if (flap_pend_q) begin
            vel_new = FlapVel;
        end else if (vel_sum > MaxFall) begin
            vel_new = MaxFall[5:0];
        end else begin
            vel_new = vel_sum[5:0];
        end
        y_sum = $signed({2'b00, box_y_q}) + 9'(vel_new);
        if (y_sum < YMin) begin
            y_clamped = 7'd1;
        end else if (y_sum > YMax) begin
            y_clamped = BoxYMax;
        end else begin
            y_clamped = y_sum[6:0];
        end
    end

    // Collision test on the post-MOVE state.
    always_comb begin
        px9     = {1'b0, pipe_x_q};
        by9     = {2'b00, box_y_q};
        py9     = {2'b00, pipe_y_q};
        hit_now = (box_y_q == 7'd1) || (box_y_q == BoxYMax)
                  || ((px9 >= XLo) && (px9 <= XHi)
                      && (((by9 - 9'd1) < py9) || ((by9 + 9'd1) > (py9 + GapSpan))));
    end

    always_comb begin
        state_d     = state_q;
        flap_pend_d = flap_pend_q | flap_edge;
        vel_d       = vel_q;
        box_y_d     = box_y_q;
        pipe_x_d    = pipe_x_q;
        pipe_y_d    = pipe_y_q;
        score_d     = score_q;
        over_d      = over_q;
        lfsr_d      = lfsr_q;
        hit_d       = hit_q;
        idle_path_d = idle_path_q;

        unique case (state_q)
            StIdle: begin
                flap_pend_d = 1'b0;
                if (tick) begin
                    state_d     = start ? StMove : StHold1;
                    idle_path_d = ~start;
                end
            end
            StRun: begin
                if (tick) state_d = StMove;
            end
            StMove: begin
                // An edge arriving in this very cycle is kept for the next frame.
                flap_pend_d = flap_edge;
                vel_d       = vel_new;
                box_y_d     = y_clamped;
                if (pipe_x_q < PipeStep) begin
                    pipe_x_d = PipeXInit;
                    pipe_y_d = 7'd8 + {1'b0, lfsr_q[5:0]};
                    score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                end else begin
                    pipe_x_d = pipe_x_q - PipeStep;
                end
                lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                state_d = StCheck;
            end
            StCheck: begin
                hit_d   = hit_now;
                state_d = StEmit;
            end
            StHold1: state_d = StHold2;
            StHold2: state_d = StEmit;
            StEmit: begin
                if (hit_q) begin
                    state_d = StDead;
                    over_d  = 1'b1;
                end else if (idle_path_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRun;
                end
            end
            StDead: begin
                if (tick) begin
                    state_d = StHold1;
                    if (start) begin
                        // Restart: game state back to reset values, lfsr keeps running.
                        vel_d       = '0;
                        box_y_d     = BoxYInit;
                        pipe_x_d    = PipeXInit;
                        pipe_y_d    = PipeYInit;
                        score_d     = '0;
                        over_d      = 1'b0;
                        hit_d       = 1'b0;
                        flap_pend_d = 1'b0;
                        idle_path_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        draw_d = (state_d == StEmit);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            flap_prev_q <= 1'b0;
            flap_pend_q <= 1'b0;
            vel_q       <= '0;
            box_y_q     <= BoxYInit;
            pipe_x_q    <= PipeXInit;
            pipe_y_q    <= PipeYInit;
            score_q     <= '0;
            over_q      <= 1'b0;
            draw_q      <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            hit_q       <= 1'b0;
            idle_path_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flap_prev_q <= flap;
            flap_pend_q <= flap_pend_d;
            vel_q       <= vel_d;
            box_y_q     <= box_y_d;
            pipe_x_q    <= pipe_x_d;
            pipe_y_q    <= pipe_y_d;
            score_q     <= score_d;
            over_q      <= over_d;
            draw_q      <= draw_d;
            lfsr_q      <= lfsr_d;
            hit_q       <= hit_d;
            idle_path_q <= idle_path_d;
        end
    end

    assign box_y      = box_y_q;
    assign pipe_1_x   = pipe_x_q;
    assign pipe_1_y   = pipe_y_q;
    assign draw_frame = draw_q;
    assign game_over  = over_q;
    assign score      = score_q;

endmodule
